// File: rtl/pooling_input_interface_if.sv
// Stream and tagged-output bundle between the conv layer, the pooling input
// interface and the pooling core.
interface pooling_input_interface_if #(
    parameter int DATA_WIDTH    = 32,
    parameter int TOTAL_FEATURE = 4,
    parameter int FEATURE_WIDTH = 6
);
    logic [DATA_WIDTH-1:0]            din;
    logic                             din_valid;
    logic                             din_ready;
    logic [DATA_WIDTH-1:0]            data_out;
    logic                             valid;
    logic                             out_ready;
    logic [$clog2(TOTAL_FEATURE)-1:0] feature_idx;
    logic [$clog2(FEATURE_WIDTH)-1:0] feature_row;
    logic [$clog2(FEATURE_WIDTH)-1:0] feature_col;

    modport master (
        output din, din_valid, out_ready,
        input  din_ready, data_out, valid, feature_idx, feature_row, feature_col
    );

    modport slave (
        input  din, din_valid, out_ready,
        output din_ready, data_out, valid, feature_idx, feature_row, feature_col
    );
endinterface

// File: rtl/pooling_input_interface.sv
// Pooling front end: buffers one conv frame through a small FIFO and tags each beat
// with feature/row/column. Optional macro POOL_IN_RELU_EN zeroes negative words.
module pooling_input_interface #(
    parameter int DATA_WIDTH    = 32,
    parameter int TOTAL_FEATURE = 4,
    parameter int FEATURE_WIDTH = 6,
    parameter int FIFO_DEPTH    = 4
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      start,
    pooling_input_interface_if.slave  bus,
    output logic                      busy,
    output logic                      frame_done
);
    localparam int FRAME_BEATS = FEATURE_WIDTH * FEATURE_WIDTH * TOTAL_FEATURE;
    localparam int CW = $clog2(FRAME_BEATS + 1);
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int IW = $clog2(TOTAL_FEATURE);
    localparam int RW = $clog2(FEATURE_WIDTH);

    localparam logic [CW-1:0] FRAME_C     = CW'(FRAME_BEATS);
    localparam logic [CW-1:0] LAST_BEAT_C = CW'(FRAME_BEATS - 1);
    localparam logic [IW-1:0] LAST_IDX_C  = IW'(TOTAL_FEATURE - 1);
    localparam logic [RW-1:0] LAST_POS_C  = RW'(FEATURE_WIDTH - 1);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t                state_q;
    logic [CW-1:0]         in_cnt_q;
    logic [CW-1:0]         out_cnt_q;
    logic [IW-1:0]         idx_q;
    logic [RW-1:0]         col_q;
    logic [RW-1:0]         row_q;
    logic [PW:0]           wr_ptr_q;
    logic [PW:0]           rd_ptr_q;
    logic [DATA_WIDTH-1:0] mem [FIFO_DEPTH];

    logic                  fifo_empty;
    logic                  fifo_full;
    logic                  push;
    logic                  pop;
    logic [DATA_WIDTH-1:0] head;

    function automatic logic [DATA_WIDTH-1:0] relu(input logic [DATA_WIDTH-1:0] w);
`ifdef POOL_IN_RELU_EN
        return w[DATA_WIDTH-1] ? '0 : w;
`else
        return w;
`endif
    endfunction

    // Extra pointer bit distinguishes full from empty when the indices coincide.
    assign fifo_empty = (wr_ptr_q == rd_ptr_q);
    assign fifo_full  = (wr_ptr_q[PW] != rd_ptr_q[PW]) &&
                        (wr_ptr_q[PW-1:0] == rd_ptr_q[PW-1:0]);

    assign bus.din_ready = (state_q == RUN) && !fifo_full && (in_cnt_q < FRAME_C);
    assign push          = bus.din_valid && bus.din_ready;
    assign pop           = bus.valid && bus.out_ready;

    assign head            = mem[rd_ptr_q[PW-1:0]];
    assign bus.valid       = !fifo_empty;
    assign bus.data_out    = fifo_empty ? '0 : relu(head);
    assign bus.feature_idx = idx_q;
    assign bus.feature_col = col_q;
    assign bus.feature_row = row_q;
    assign busy            = (state_q != IDLE);
    assign frame_done      = (state_q == DONE);

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr_q[PW-1:0]] <= bus.din;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            in_cnt_q  <= '0;
            out_cnt_q <= '0;
            idx_q     <= '0;
            col_q     <= '0;
            row_q     <= '0;
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (start) begin
                        state_q   <= RUN;
                        in_cnt_q  <= '0;
                        out_cnt_q <= '0;
                        idx_q     <= '0;
                        col_q     <= '0;
                        row_q     <= '0;
                        wr_ptr_q  <= '0;
                        rd_ptr_q  <= '0;
                    end
                end
                RUN: begin
                    if (push) begin
                        wr_ptr_q <= wr_ptr_q + 1'b1;
                        in_cnt_q <= in_cnt_q + 1'b1;
                    end
                    if (pop) begin
                        rd_ptr_q  <= rd_ptr_q + 1'b1;
                        out_cnt_q <= out_cnt_q + 1'b1;
                        // Feature is innermost, then column, then row.
                        if (idx_q == LAST_IDX_C) begin
                            idx_q <= '0;
                            if (col_q == LAST_POS_C) begin
                                col_q <= '0;
                                row_q <= (row_q == LAST_POS_C) ? '0 : row_q + 1'b1;
                            end else begin
                                col_q <= col_q + 1'b1;
                            end
                        end else begin
                            idx_q <= idx_q + 1'b1;
                        end
                        if (out_cnt_q == LAST_BEAT_C) begin
                            state_q <= DONE;
                        end
                    end
                end
                DONE:    state_q <= IDLE;
                default: state_q <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_pooling_input_interface.sv
// Directed bench for pooling_input_interface: full frames, stalls, random
// handshakes, overflow offers, mid-frame reset and the sign-bit path.
module tb_pooling_input_interface;
    localparam int FRAME = 144;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic start = 1'b0;
    logic busy;
    logic frame_done;

    pooling_input_interface_if bus ();

    pooling_input_interface dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .bus        (bus),
        .busy       (busy),
        .frame_done (frame_done)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;
    int in_k, out_k, done_cnt;
    int vpct, rpct, offer_lim;

    function automatic logic [31:0] f32(input int k);
        int e;
        logic [31:0] m;
        if (k <= 0) return 32'h0;
        e = 0;
        for (int i = 0; i < 31; i++) if (((k >> i) & 1) != 0) e = i;
        m = 32'(k) << (23 - e);
        return {1'b0, 8'(127 + e), m[22:0]};
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One clock: score a pop against the beat formula, then drive the next inputs.
    task automatic tick();
        bit do_push, do_pop;
        do_push = bus.din_valid && bus.din_ready;
        do_pop  = bus.valid && bus.out_ready;
        if (do_pop) begin
            check("data", bus.data_out, f32(out_k));
            check("idx", 32'(bus.feature_idx), out_k % 4);
            check("col", 32'(bus.feature_col), (out_k / 4) % 6);
            check("row", 32'(bus.feature_row), out_k / 24);
            if (out_k == 37) begin
                check("b37_idx", 32'(bus.feature_idx), 1);
                check("b37_col", 32'(bus.feature_col), 3);
                check("b37_row", 32'(bus.feature_row), 1);
            end
            if (out_k == 143) begin
                check("b143_idx", 32'(bus.feature_idx), 3);
                check("b143_col", 32'(bus.feature_col), 5);
                check("b143_row", 32'(bus.feature_row), 5);
            end
            out_k++;
        end
        @(posedge clk);
        #1;
        if (do_push) in_k++;
        if (frame_done) done_cnt++;
        if (in_k == FRAME) check("no_overaccept", 32'(bus.din_ready), 0);
        bus.din_valid = (in_k < offer_lim) && ($urandom_range(0, 99) < vpct);
        bus.din       = f32(in_k);
        bus.out_ready = ($urandom_range(0, 99) < rpct);
    endtask

    task automatic start_frame();
        in_k = 0;
        out_k = 0;
        done_cnt = 0;
        start = 1'b1;
        tick();
        start = 1'b0;
        check("busy_after_start", 32'(busy), 1);
    endtask

    task automatic run_until_done(input int budget);
        int c;
        c = 0;
        while (!frame_done && c < budget) begin
            tick();
            c++;
        end
        check("done_in_budget", 32'(frame_done), 1);
        check("in_count", in_k, FRAME);
        check("out_count", out_k, FRAME);
    endtask

    initial begin
        bus.din = '0;
        bus.din_valid = 1'b0;
        bus.out_ready = 1'b0;
        vpct = 100;
        rpct = 100;
        offer_lim = FRAME;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;

        // Reset values
        check("rst_din_ready", 32'(bus.din_ready), 0);
        check("rst_valid", 32'(bus.valid), 0);
        check("rst_data", bus.data_out, 0);
        check("rst_idx", 32'(bus.feature_idx), 0);
        check("rst_row", 32'(bus.feature_row), 0);
        check("rst_col", 32'(bus.feature_col), 0);
        check("rst_busy", 32'(busy), 0);
        check("rst_done", 32'(frame_done), 0);

        // Full frame, streaming both sides
        bus.out_ready = 1'b1;
        start_frame();
        check("first_ready", 32'(bus.din_ready), 1);
        check("first_latency_valid", 32'(bus.valid), 0);
        tick();
        check("beat0_valid", 32'(bus.valid), 1);
        check("beat0_data", bus.data_out, 32'h0);
        run_until_done(400);
        check("busy_in_done", 32'(busy), 1);
        tick();
        check("busy_dropped", 32'(busy), 0);
        check("done_pulse_once", 32'(frame_done), 0);
        check("done_count", done_cnt, 1);

        // Consumer stalled: FIFO fills and head holds
        rpct = 0;
        bus.out_ready = 1'b0;
        start_frame();
        repeat (4) tick();
        for (int i = 0; i < 6; i++) begin
            tick();
            check("stall_ready", 32'(bus.din_ready), 0);
            check("stall_valid", 32'(bus.valid), 1);
            check("stall_data", bus.data_out, 32'h0);
            check("stall_idx", 32'(bus.feature_idx), 0);
            check("stall_col", 32'(bus.feature_col), 0);
            check("stall_row", 32'(bus.feature_row), 0);
        end
        check("stall_accepts", in_k, 4);
        rpct = 100;
        bus.out_ready = 1'b1;
        run_until_done(400);
        tick();

        // Random handshakes on both sides
        vpct = 50;
        rpct = 50;
        start_frame();
        run_until_done(3000);
        tick();

        // Over-offer: 150 beats offered, only a frame's worth taken
        vpct = 100;
        rpct = 100;
        offer_lim = 150;
        start_frame();
        run_until_done(400);
        repeat (5) tick();
        check("overflow_in_count", in_k, FRAME);
        check("overflow_done_once", done_cnt, 1);
        offer_lim = FRAME;

        // Asynchronous reset mid-frame, then a clean frame
        start_frame();
        for (int c = 0; c < 400 && out_k < 60; c++) tick();
        check("reached_beat60", out_k, 60);
        rst = 1'b1;
        #1;
        check("arst_valid", 32'(bus.valid), 0);
        check("arst_busy", 32'(busy), 0);
        check("arst_ready", 32'(bus.din_ready), 0);
        check("arst_data", bus.data_out, 0);
        check("arst_idx", 32'(bus.feature_idx), 0);
        check("arst_col", 32'(bus.feature_col), 0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        check("post_rst_valid", 32'(bus.valid), 0);
        check("post_rst_busy", 32'(busy), 0);
        start_frame();
        run_until_done(400);
        tick();

        // Sign-bit handling of the head word
        vpct = 0;
        bus.din_valid = 1'b0;
        bus.out_ready = 1'b0;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        bus.din = 32'hBF800000;
        bus.din_valid = 1'b1;
        @(posedge clk);
        #1;
        bus.din = 32'h3F800000;
        @(posedge clk);
        #1;
        bus.din_valid = 1'b0;
`ifdef POOL_IN_RELU_EN
        check("neg_word", bus.data_out, 32'h0);
`else
        check("neg_word", bus.data_out, 32'hBF800000);
`endif
        check("neg_idx", 32'(bus.feature_idx), 0);
        bus.out_ready = 1'b1;
        @(posedge clk);
        #1;
        bus.out_ready = 1'b0;
        check("pos_word", bus.data_out, 32'h3F800000);
        check("pos_idx", 32'(bus.feature_idx), 1);
        rst = 1'b1;
        @(posedge clk);
        #1;

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/pooling_input_interface.md
Name: pooling_input_interface

Overview:
Front end of the pooling layer. Accepts the convolution layer's serial feature-map stream under a valid/ready handshake and buffers it in a small FIFO. It tags every beat with feature index, row and column and presents it to the pooling core. The feature_idx/feature_row/valid it produces are the signals the pooling output stage consumes to capture results on rows 1, 3 and 5.

Parameters:
DATA_WIDTH, 32, word width (IEEE-754 single)
TOTAL_FEATURE, 4, feature maps interleaved per pixel
FEATURE_WIDTH, 6, conv output map is FEATURE_WIDTH x FEATURE_WIDTH
FIFO_DEPTH, 4, buffer entries (power of two, >=2)

Ports:
clk  in  1  clock
rst  in  1  asynchronous reset, active-high
start  in  1  one-cycle pulse, begins a frame
din  in  DATA_WIDTH  conv output word
din_valid  in  1  din is valid
din_ready  out  1  block accepts din this cycle
data_out  out  DATA_WIDTH  word to pooling core (FIFO head)
valid  out  1  data_out and tags valid
out_ready  in  1  pooling core consumes this cycle
feature_idx  out  $clog2(TOTAL_FEATURE)  feature of current beat
feature_row  out  $clog2(FEATURE_WIDTH)  row of current beat
feature_col  out  $clog2(FEATURE_WIDTH)  column of current beat
busy  out  1  frame in progress
frame_done  out  1  one-cycle pulse after last beat consumed

Behaviour:
- Stream order: row-major pixels; feature innermost. Beat k -> feature = k mod TOTAL_FEATURE, col = (k / TOTAL_FEATURE) mod FEATURE_WIDTH, row = k / (TOTAL_FEATURE*FEATURE_WIDTH). Frame = FRAME_BEATS = FEATURE_WIDTH^2 * TOTAL_FEATURE beats (144 by default).
- FSM states:
  - IDLE: start -> RUN; clears in/out beat counters and FIFO pointers.
  - RUN: out beat counter reaches FRAME_BEATS -> DONE.
  - DONE: lasts one cycle -> IDLE.
- start is ignored in RUN and DONE.
- busy = (state != IDLE).
- din_ready = RUN && !fifo_full && in_count < FRAME_BEATS. Words beyond FRAME_BEATS are not accepted.
- Push on din_valid && din_ready. The write is registered: a word accepted in cycle N is visible on data_out with valid=1 in cycle N+1 at the earliest.
- valid = !fifo_empty. data_out = FIFO head. Tags come from the output-side counters.
- Pop on valid && out_ready. On each pop, feature_idx increments; on its wrap, feature_col increments; on its wrap, feature_row increments.
- While valid && !out_ready, data_out and all tags are held stable.
- Full FIFO: din_ready is low. There is no push-through bypass even if a pop occurs in the same cycle.
- Simultaneous push and pop on a non-full, non-empty FIFO: occupancy is unchanged and both operations complete.
- frame_done = 1 exactly in the DONE cycle, i.e. the cycle after the final pop.
- Reset values: din_ready=0, valid=0, data_out=0, feature_idx/row/col=0, busy=0, frame_done=0. FIFO is emptied, state=IDLE.
- Reset mid-frame discards all buffered data and counters immediately (asynchronous).

Optional Feature:
POOL_IN_RELU_EN. When defined, data_out is forced to all zeros whenever the FIFO head has its sign bit (bit DATA_WIDTH-1) set, applying ReLU ahead of max pooling. Tags and the handshake are unchanged. When undefined, data_out is the FIFO head unmodified.

Test Plan:
- Reset, then start, then 144 consecutive beats with din = beat index (as float) and out_ready=1 -> beat 0 emerges at cycle +1; beat 37 tagged idx=1, col=3, row=1; beat 143 tagged idx=3, col=5, row=5; frame_done pulses one cycle after the last pop; busy then drops.
- out_ready=0 during RUN -> after 4 accepts din_ready=0 and valid=1 with data_out held at beat 0 with tags 0/0/0; releasing out_ready drains in order with no loss or duplication.
- Random din_valid and out_ready (50%) over a full frame -> output sequence equals input sequence and tags match the formula for every beat.
- Offer 150 beats -> only 144 accepted (din_ready low after in_count=144); frame_done fires once.
- Assert rst at beat 60 -> valid=0, FIFO empty, state IDLE next edge; a new start runs a full correct frame from beat 0.
- With POOL_IN_RELU_EN: din=32'hBF800000 (-1.0) -> data_out=0; din=32'h3F800000 (1.0) -> passed unchanged.
